// File: rtl/keccak_rho_pi_seq_pkg.sv
// Shared constants, types and lookup tables for the Keccak rho+pi sequencer.
package keccak_rho_pi_seq_pkg;

   localparam int LANE_W  = 64;
   localparam int N_LANES = 25;
   localparam int CNT_W   = 5;
   localparam int ROT_W   = 6;

   localparam logic [CNT_W-1:0] LAST_LANE = 5'd24;

   typedef enum logic {
      S_LOAD,
      S_EMIT
   } state_e;

   // One ROM word: which input lane feeds output lane j, and by how much it rotates.
   typedef struct packed {
      logic [CNT_W-1:0] src;
      logic [ROT_W-1:0] rot;
   } rom_entry_t;

   // Rotation offsets r[x,y], indexed by input lane i = x + 5y.
   localparam logic [ROT_W-1:0] RHO_OFFS [N_LANES] = '{
      6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
      6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
      6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
      6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
      6'd18, 6'd2,  6'd61, 6'd56, 6'd14
   };

   // Source input lane for each output lane j = X + 5Y: src = ((3Y + X) % 5) + 5X.
   localparam logic [CNT_W-1:0] PI_SRC [N_LANES] = '{
      5'd0,  5'd6,  5'd12, 5'd18, 5'd24,
      5'd3,  5'd9,  5'd10, 5'd16, 5'd22,
      5'd1,  5'd7,  5'd13, 5'd19, 5'd20,
      5'd4,  5'd5,  5'd11, 5'd17, 5'd23,
      5'd2,  5'd8,  5'd14, 5'd15, 5'd21
   };

endpackage

// File: rtl/keccak_rho_pi_seq_rho_pi_rom.sv
// Combinational lookup: output lane index -> {source lane, rotate amount}.
module keccak_rho_pi_seq_rho_pi_rom
   import keccak_rho_pi_seq_pkg::*;
(
   input  logic [CNT_W-1:0] lane_idx_i,
   output rom_entry_t       entry_o
);

   // Table lookup, guarded so out-of-range indices read as zero.
   always_comb begin
      // NOTE: default every output first so no path through the block infers a latch.
      entry_o = '0;
      if (lane_idx_i <= LAST_LANE) begin
         entry_o.src = PI_SRC[lane_idx_i];
         entry_o.rot = RHO_OFFS[PI_SRC[lane_idx_i]];
      end
   end

endmodule

// File: rtl/keccak_rho_pi_seq.sv
// Keccak rho+pi sequencer: buffers one 25-lane state, then streams out
// B[j] = ROL(A[src(j)], RHO[src(j)]) through a single shared 64-bit rotator.
module keccak_rho_pi_seq
   import keccak_rho_pi_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [LANE_W-1:0] in_lane_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [LANE_W-1:0] out_lane_o,
   output logic              out_last_o,
   output logic              busy_o
);

   state_e            state_q;
   logic [CNT_W-1:0]  in_cnt_q;
   logic [CNT_W-1:0]  out_cnt_q;
   logic [LANE_W-1:0] lane_buf_q [N_LANES];
   logic [LANE_W-1:0] out_lane_q;
   logic              out_valid_q;
   logic              out_last_q;

   rom_entry_t        rom_entry;
   logic [LANE_W-1:0] rot_src;
   logic [LANE_W-1:0] rot_shl;
   logic [LANE_W-1:0] rot_shr;
   logic [LANE_W-1:0] out_lane_d;
   logic              in_fire;
   logic              load_en;
   logic              done_fire;

   keccak_rho_pi_seq_rho_pi_rom u_rom (
      .lane_idx_i (out_cnt_q),
      .entry_o    (rom_entry)
   );

   assign in_fire   = (state_q == S_LOAD) && in_valid_i;
   assign done_fire = out_valid_q && out_ready_i && out_last_q;
   // Refill the output register when it is empty or being drained, but never
   // after the final lane has been loaded and is still waiting for its handshake.
   assign load_en   = (state_q == S_EMIT) && (!out_valid_q || out_ready_i)
                      && !(out_valid_q && out_last_q);

   // Shared rotator; a zero rotate must not shift right by the full lane width.
   always_comb begin
      rot_src    = lane_buf_q[rom_entry.src];
      rot_shl    = rot_src << rom_entry.rot;
      rot_shr    = (rom_entry.rot == '0) ? '0
                   : rot_src >> (7'd64 - {1'b0, rom_entry.rot});
      out_lane_d = rot_shl | rot_shr;
   end

   // Lane buffer: written in input order during S_LOAD.
   always_ff @(posedge clk) begin
      // NOTE: the buffer has no reset; its contents are always overwritten before being read.
      if (in_fire) begin
         lane_buf_q[in_cnt_q] <= in_lane_i;
      end
   end

   // Control FSM, counters and registered output lane.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state_q     <= S_LOAD;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_lane_q  <= '0;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (in_fire) begin
                  if (in_cnt_q == LAST_LANE) begin
                     in_cnt_q <= '0;
                     state_q  <= S_EMIT;
                  end else begin
                     in_cnt_q <= in_cnt_q + 1'b1;
                  end
               end
            end
            S_EMIT: begin
               if (load_en) begin
                  out_lane_q  <= out_lane_d;
                  out_last_q  <= (out_cnt_q == LAST_LANE);
                  out_valid_q <= 1'b1;
                  out_cnt_q   <= (out_cnt_q == LAST_LANE) ? '0 : out_cnt_q + 1'b1;
               end else if (done_fire) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  out_cnt_q   <= '0;
                  state_q     <= S_LOAD;
               end
            end
            default: state_q <= S_LOAD;
         endcase
      end
   end

   assign in_ready_o  = (state_q == S_LOAD);
   assign busy_o      = (state_q == S_EMIT);
   assign out_valid_o = out_valid_q;
   assign out_lane_o  = out_lane_q;
   assign out_last_o  = out_last_q;

endmodule
